// File: rtl/hybrid_noc_be_output_arbiter.sv
// Best-effort output arbiter: packet-level round-robin across router inputs, one-entry
// output register, and TDM override that stalls BE traffic without losing flits.
module hybrid_noc_be_output_arbiter #(
   parameter int unsigned FLIT_WIDTH = 32,
   parameter int unsigned PORTS      = 5,
   parameter int unsigned PTR_W      = $clog2(PORTS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [PORTS*FLIT_WIDTH-1:0] in_flit,
   input  logic [PORTS-1:0]            in_valid,
   input  logic [PORTS-1:0]            in_last,
   output logic [PORTS-1:0]            in_ready,
   input  logic                        tdm_active,
   output logic [FLIT_WIDTH-1:0]       out_flit,
   output logic                        out_valid,
   output logic                        out_last,
   input  logic                        out_ready
);

   typedef enum logic [0:0] {StIdle, StLocked} state_e;

   state_e                state_q, state_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic [PTR_W-1:0]      grant_q, grant_d;
   logic [PTR_W-1:0]      winner, sel, ptr_inc;
   logic [PTR_W:0]        idx;
   logic                  found;
   logic                  reg_valid_q;
   logic [FLIT_WIDTH-1:0] reg_flit_q;
   logic                  reg_last_q;
   logic                  drain, load_en, accept, sel_last;
   logic [FLIT_WIDTH-1:0] sel_flit;

   assign out_valid = reg_valid_q & ~tdm_active;
   assign out_flit  = reg_flit_q;
   assign out_last  = reg_last_q;
   assign drain     = out_valid & out_ready;
   assign load_en   = ~reg_valid_q | drain;

   // Round-robin search starting at ptr, wrapping at PORTS.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int unsigned k = 0; k < PORTS; k++) begin
         idx = {1'b0, ptr_q} + (PTR_W+1)'(k);
         if (idx >= (PTR_W+1)'(PORTS)) begin
            idx = idx - (PTR_W+1)'(PORTS);
         end
         if (!found && in_valid[idx[PTR_W-1:0]]) begin
            found  = 1'b1;
            winner = idx[PTR_W-1:0];
         end
      end
   end

   assign ptr_inc = (winner == PTR_W'(PORTS - 1)) ? '0 : winner + PTR_W'(1);

   always_comb begin
      in_ready = '0;
      sel      = (state_q == StLocked) ? grant_q : winner;
      if (rst && ((state_q == StLocked) || found)) begin
         in_ready[sel] = load_en & ~tdm_active;
      end
   end

   assign accept   = in_valid[sel] & in_ready[sel];
   assign sel_last = in_last[sel];
   assign sel_flit = in_flit[int'(sel)*FLIT_WIDTH +: FLIT_WIDTH];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               grant_d = winner;
               ptr_d   = ptr_inc;
               if (!sel_last) begin
                  state_d = StLocked;
               end
            end
         end
         StLocked: begin
            if (accept && sel_last) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         grant_q     <= '0;
         reg_valid_q <= 1'b0;
         reg_flit_q  <= '0;
         reg_last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         // Drain and reload in the same cycle keeps the link at full throughput.
         if (load_en) begin
            reg_valid_q <= accept;
            if (accept) begin
               reg_flit_q <= sel_flit;
               reg_last_q <= sel_last;
            end
         end
      end
   end

endmodule

// File: tb/tb_hybrid_noc_be_output_arbiter.sv
// Directed bench for the BE output arbiter: upstream packet sources, output log, and
// per-scenario checks of ordering, latency, TDM stall, backpressure and reset.
module tb_hybrid_noc_be_output_arbiter;

   localparam int unsigned FW = 32;
   localparam int unsigned NP = 5;

   logic             clk, rst, tdm_active, out_ready, out_valid, out_last;
   logic [NP*FW-1:0] in_flit;
   logic [NP-1:0]    in_valid, in_last, in_ready;
   logic [FW-1:0]    out_flit;

   hybrid_noc_be_output_arbiter #(.FLIT_WIDTH(FW), .PORTS(NP)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_flit    (in_flit),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .tdm_active (tdm_active),
      .out_flit   (out_flit),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .out_ready  (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [FW-1:0] flit;
      logic          last;
      int            cyc;
   } obs_t;

   obs_t        out_log[$];
   logic [FW:0] src_mem [NP][8];
   int          src_head [NP];
   int          src_tail [NP];
   int          acc_cnt [NP];
   int          acc_first_cyc [NP];
   int          cyc;
   int          n_cmp, n_err;

   function automatic logic [FW-1:0] mk(input int src, input int pkt, input int n);
      return {8'(src), 8'(pkt), 16'(n)};
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < NP; i++) begin
         if (src_head[i] < src_tail[i]) begin
            in_valid[i]           = 1'b1;
            in_flit[i*FW +: FW]   = src_mem[i][src_head[i]][FW-1:0];
            in_last[i]            = src_mem[i][src_head[i]][FW];
         end else begin
            in_valid[i]           = 1'b0;
            in_flit[i*FW +: FW]   = '0;
            in_last[i]            = 1'b0;
         end
      end
   endtask

   task automatic clear_tb();
      for (int i = 0; i < NP; i++) begin
         src_head[i] = 0;
         src_tail[i] = 0;
         acc_cnt[i]  = 0;
         acc_first_cyc[i] = -1;
      end
      out_log.delete();
      drive_inputs();
   endtask

   task automatic push(input int src, input logic [FW-1:0] flit, input logic last);
      src_mem[src][src_tail[src]] = {last, flit};
      src_tail[src]++;
      drive_inputs();
   endtask

   // Sample handshakes mid-cycle, then advance the upstream sources after the edge.
   task automatic step();
      logic [NP-1:0] acc;
      obs_t o;
      @(negedge clk);
      acc = in_valid & in_ready;
      if (out_valid && out_ready) begin
         o.flit = out_flit;
         o.last = out_last;
         o.cyc  = cyc;
         out_log.push_back(o);
      end
      for (int i = 0; i < NP; i++) begin
         if (acc[i] && acc_cnt[i] == 0) acc_first_cyc[i] = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NP; i++) begin
         if (acc[i]) begin
            src_head[i]++;
            acc_cnt[i]++;
         end
      end
      drive_inputs();
   endtask

   task automatic run_until_out(input int n);
      for (int b = 0; b < 40 && out_log.size() < n; b++) step();
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      clear_tb();
      rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      push(1, mk(1, 0, 0), 1'b1);
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if (out_flit !== '0) begin n_err++; $display("FAIL reset_out_flit got %h want 0", out_flit); end
      n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last got %b want 0", out_last); end
      n_cmp++; if (in_ready !== 5'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 00000", in_ready); end
      n_cmp++; if (dut.ptr_q !== 3'd0) begin n_err++; $display("FAIL reset_ptr got %0d want 0", dut.ptr_q); end
      clear_tb();
      rst = 1'b1;
      #1;
   endtask

   task automatic test_single_packet();
      for (int k = 0; k < 3; k++) push(2, mk(2, 1, k), k == 2);
      run_until_out(3);
      repeat (3) step();
      n_cmp++;
      if (out_log.size() != 3) begin
         n_err++; $display("FAIL single_count got %0d want 3", out_log.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_cmp++; if (out_log[k].flit !== mk(2, 1, k)) begin n_err++; $display("FAIL single_flit%0d got %h want %h", k, out_log[k].flit, mk(2, 1, k)); end
            n_cmp++; if (out_log[k].last !== (k == 2)) begin n_err++; $display("FAIL single_last%0d got %b want %b", k, out_log[k].last, k == 2); end
            n_cmp++; if (out_log[k].cyc != acc_first_cyc[2] + 1 + k) begin n_err++; $display("FAIL single_cycle%0d got %0d want %0d", k, out_log[k].cyc, acc_first_cyc[2] + 1 + k); end
         end
      end
      n_cmp++; if (dut.ptr_q !== 3'd3) begin n_err++; $display("FAIL single_ptr got %0d want 3", dut.ptr_q); end
   endtask

   task automatic test_round_robin();
      logic [FW-1:0] exp_f [6];
      logic          exp_l [6];
      apply_reset();
      for (int k = 0; k < 2; k++) begin
         push(0, mk(0, 2, k), k == 1);
         push(3, mk(3, 2, k), k == 1);
      end
      exp_f[0] = mk(0, 2, 0); exp_l[0] = 1'b0;
      exp_f[1] = mk(0, 2, 1); exp_l[1] = 1'b1;
      exp_f[2] = mk(3, 2, 0); exp_l[2] = 1'b0;
      exp_f[3] = mk(3, 2, 1); exp_l[3] = 1'b1;
      run_until_out(4);
      repeat (2) step();
      n_cmp++; if (dut.ptr_q !== 3'd4) begin n_err++; $display("FAIL rr_ptr got %0d want 4", dut.ptr_q); end
      // ptr=4: search 4,0,... so input 0 beats input 3 again.
      push(0, mk(0, 3, 0), 1'b1);
      push(3, mk(3, 3, 0), 1'b1);
      exp_f[4] = mk(0, 3, 0); exp_l[4] = 1'b1;
      exp_f[5] = mk(3, 3, 0); exp_l[5] = 1'b1;
      run_until_out(6);
      repeat (3) step();
      n_cmp++;
      if (out_log.size() != 6) begin
         n_err++; $display("FAIL rr_count got %0d want 6", out_log.size());
      end else begin
         for (int k = 0; k < 6; k++) begin
            n_cmp++; if (out_log[k].flit !== exp_f[k]) begin n_err++; $display("FAIL rr_flit%0d got %h want %h", k, out_log[k].flit, exp_f[k]); end
            n_cmp++; if (out_log[k].last !== exp_l[k]) begin n_err++; $display("FAIL rr_last%0d got %b want %b", k, out_log[k].last, exp_l[k]); end
         end
      end
      n_cmp++; if (dut.ptr_q !== 3'd4) begin n_err++; $display("FAIL rr_ptr2 got %0d want 4", dut.ptr_q); end
   endtask

   task automatic test_wrap();
      clear_tb();
      push(1, mk(1, 4, 0), 1'b1);
      push(4, mk(4, 4, 0), 1'b1);
      run_until_out(2);
      repeat (3) step();
      n_cmp++;
      if (out_log.size() != 2) begin
         n_err++; $display("FAIL wrap_count got %0d want 2", out_log.size());
      end else begin
         n_cmp++; if (out_log[0].flit !== mk(4, 4, 0)) begin n_err++; $display("FAIL wrap_first got %h want %h", out_log[0].flit, mk(4, 4, 0)); end
         n_cmp++; if (out_log[1].flit !== mk(1, 4, 0)) begin n_err++; $display("FAIL wrap_second got %h want %h", out_log[1].flit, mk(1, 4, 0)); end
         n_cmp++; if (out_log[1].cyc != out_log[0].cyc + 1) begin n_err++; $display("FAIL wrap_b2b got %0d want %0d", out_log[1].cyc, out_log[0].cyc + 1); end
      end
      n_cmp++; if (dut.ptr_q !== 3'd2) begin n_err++; $display("FAIL wrap_ptr got %0d want 2", dut.ptr_q); end
   endtask

   task automatic test_tdm_stall();
      clear_tb();
      for (int k = 0; k < 4; k++) push(0, mk(0, 5, k), k == 3);
      for (int b = 0; b < 20 && acc_cnt[0] < 2; b++) step();
      n_cmp++; if (acc_cnt[0] != 2) begin n_err++; $display("FAIL tdm_reach got %0d want 2", acc_cnt[0]); end
      push(1, mk(1, 5, 0), 1'b1);
      tdm_active = 1'b1;
      for (int t = 0; t < 2; t++) begin
         #1;
         n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL tdm_out_valid%0d got %b want 0", t, out_valid); end
         n_cmp++; if (in_ready !== 5'b0) begin n_err++; $display("FAIL tdm_in_ready%0d got %b want 00000", t, in_ready); end
         step();
      end
      tdm_active = 1'b0;
      run_until_out(5);
      repeat (3) step();
      n_cmp++;
      if (out_log.size() != 5) begin
         n_err++; $display("FAIL tdm_count got %0d want 5", out_log.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_cmp++; if (out_log[k].flit !== mk(0, 5, k)) begin n_err++; $display("FAIL tdm_flit%0d got %h want %h", k, out_log[k].flit, mk(0, 5, k)); end
         end
         n_cmp++; if (out_log[3].last !== 1'b1) begin n_err++; $display("FAIL tdm_last got %b want 1", out_log[3].last); end
         n_cmp++; if (out_log[4].flit !== mk(1, 5, 0)) begin n_err++; $display("FAIL tdm_held_grant got %h want %h", out_log[4].flit, mk(1, 5, 0)); end
      end
   endtask

   task automatic test_backpressure();
      clear_tb();
      for (int k = 0; k < 3; k++) push(2, mk(2, 6, k), k == 2);
      for (int b = 0; b < 20 && out_valid !== 1'b1; b++) step();
      out_ready = 1'b0;
      for (int t = 0; t < 3; t++) begin
         #1;
         n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid%0d got %b want 1", t, out_valid); end
         n_cmp++; if (out_flit !== mk(2, 6, 0)) begin n_err++; $display("FAIL bp_hold%0d got %h want %h", t, out_flit, mk(2, 6, 0)); end
         n_cmp++; if (in_ready !== 5'b0) begin n_err++; $display("FAIL bp_in_ready%0d got %b want 00000", t, in_ready); end
         step();
      end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 5'b00100) begin n_err++; $display("FAIL bp_reload_ready got %b want 00100", in_ready); end
      step();
      n_cmp++; if (out_flit !== mk(2, 6, 1)) begin n_err++; $display("FAIL bp_next got %h want %h", out_flit, mk(2, 6, 1)); end
      run_until_out(3);
      repeat (2) step();
      n_cmp++;
      if (out_log.size() != 3) begin
         n_err++; $display("FAIL bp_count got %0d want 3", out_log.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_cmp++; if (out_log[k].flit !== mk(2, 6, k)) begin n_err++; $display("FAIL bp_flit%0d got %h want %h", k, out_log[k].flit, mk(2, 6, k)); end
         end
      end
   endtask

   task automatic test_reset_mid_packet();
      clear_tb();
      for (int k = 0; k < 4; k++) push(3, mk(3, 7, k), k == 3);
      for (int b = 0; b < 20 && acc_cnt[3] < 2; b++) step();
      #2;
      rst = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
      n_cmp++; if (in_ready !== 5'b0) begin n_err++; $display("FAIL rstmid_in_ready got %b want 00000", in_ready); end
      clear_tb();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      n_cmp++; if (dut.ptr_q !== 3'd0) begin n_err++; $display("FAIL rstmid_ptr got %0d want 0", dut.ptr_q); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_idle_valid got %b want 0", out_valid); end
      push(1, mk(1, 8, 0), 1'b1);
      run_until_out(1);
      repeat (3) step();
      n_cmp++;
      if (out_log.size() != 1) begin
         n_err++; $display("FAIL rstmid_count got %0d want 1", out_log.size());
      end else begin
         n_cmp++; if (out_log[0].flit !== mk(1, 8, 0)) begin n_err++; $display("FAIL rstmid_flit got %h want %h", out_log[0].flit, mk(1, 8, 0)); end
         n_cmp++; if (out_log[0].last !== 1'b1) begin n_err++; $display("FAIL rstmid_last got %b want 1", out_log[0].last); end
      end
   endtask

   initial begin
      clk        = 1'b0;
      rst        = 1'b0;
      tdm_active = 1'b0;
      out_ready  = 1'b1;
      in_valid   = '0;
      in_flit    = '0;
      in_last    = '0;
      cyc        = 0;
      n_cmp      = 0;
      n_err      = 0;
      clear_tb();
      test_reset();
      test_single_packet();
      test_round_robin();
      test_wrap();
      test_tdm_stall();
      test_backpressure();
      test_reset_mid_packet();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
